// File: rtl/io_uart_tx.sv
// CPU I/O-port UART sink: 64-bit words are queued in a FIFO and sent as eight 8N1 bytes, LSB byte first.
// Optional build macro IO_TX_NEWLINE_EN appends one 0x0A frame after every word.
module io_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          io_write,
   input  logic [63:0]                   io_data,
   output logic                          tx,
   output logic                          busy,
   output logic                          fifo_full,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   LVL_FULL = (AW + 1)'(FIFO_DEPTH);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
`ifdef IO_TX_NEWLINE_EN
   localparam logic [2:0] ST_NL    = 3'd4;
`endif

   logic [63:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          overflow_q, overflow_d;
   logic [2:0]    state_q, state_d;
   logic [CW-1:0] bit_cnt_q, bit_cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [2:0]    byte_idx_q, byte_idx_d;
   logic [63:0]   shift_q, shift_d;
   logic          tx_q, tx_d;
`ifdef IO_TX_NEWLINE_EN
   logic          nl_q, nl_d;
`endif
   logic          full, pop, push, bit_end;
   logic [7:0]    cur_byte;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      full       = (level_q == LVL_FULL);
      pop        = (state_q == ST_IDLE) && (level_q != '0);
      push       = io_write && (!full || pop);
      wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      overflow_d = overflow_q | (io_write & full & ~pop);
      level_d    = level_q;
      if (push && !pop)      level_d = level_q + (AW + 1)'(1);
      else if (pop && !push) level_d = level_q - (AW + 1)'(1);

      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
`ifdef IO_TX_NEWLINE_EN
      nl_d       = nl_q;
`endif
      cur_byte   = shift_q[7:0];
      bit_end    = (bit_cnt_q == CNT_MAX);

      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               shift_d    = mem_q[rd_ptr_q];
               byte_idx_d = 3'd0;
               bit_cnt_d  = '0;
               state_d    = ST_START;
               tx_d       = 1'b0;
            end
         end
`ifdef IO_TX_NEWLINE_EN
         ST_START, ST_NL: begin
`else
         ST_START: begin
`endif
            if (bit_end) begin
               bit_cnt_d = '0;
               bit_idx_d = 3'd0;
               state_d   = ST_DATA;
               tx_d      = cur_byte[0];
            end else begin
               bit_cnt_d = bit_cnt_q + CW'(1);
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               bit_cnt_d = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = cur_byte[bit_idx_d];
               end
            end else begin
               bit_cnt_d = bit_cnt_q + CW'(1);
            end
         end
         ST_STOP: begin
            if (!bit_end) begin
               bit_cnt_d = bit_cnt_q + CW'(1);
            end else begin
               bit_cnt_d = '0;
`ifdef IO_TX_NEWLINE_EN
               if (nl_q) begin
                  nl_d    = 1'b0;
                  state_d = ST_IDLE;
               end else if (byte_idx_q == 3'd7) begin
                  // The newline frame reuses the data path with 0x0A in the low byte.
                  shift_d = {56'd0, 8'h0A};
                  nl_d    = 1'b1;
                  state_d = ST_NL;
                  tx_d    = 1'b0;
               end else begin
`else
               if (byte_idx_q == 3'd7) begin
                  state_d = ST_IDLE;
               end else begin
`endif
                  shift_d    = shift_q >> 8;
                  byte_idx_d = byte_idx_q + 3'd1;
                  state_d    = ST_START;
                  tx_d       = 1'b0;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         bit_idx_q  <= 3'd0;
         byte_idx_q <= 3'd0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
`ifdef IO_TX_NEWLINE_EN
         nl_q       <= 1'b0;
`endif
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
`ifdef IO_TX_NEWLINE_EN
         nl_q       <= nl_d;
`endif
      end
   end

   // NOTE: FIFO storage is not reset; level_q guards against reading stale entries.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= io_data;
   end

   assign tx         = tx_q;
   assign busy       = (state_q != ST_IDLE) || (level_q != '0);
   assign fifo_full  = full;
   assign overflow   = overflow_q;
   assign fifo_level = level_q;

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed self-checking bench for io_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4) with a UART line decoder.
// Honours IO_TX_NEWLINE_EN: expects a trailing 0x0A frame and 90-bit word time when defined.
module tb_io_uart_tx;

   localparam int CPB = 4;
   localparam int DEPTH = 4;
`ifdef IO_TX_NEWLINE_EN
   localparam int BPW = 9;
`else
   localparam int BPW = 8;
`endif
   localparam int WORD_CYC = BPW * 10 * CPB;
   localparam int FIRST_PT = CPB + CPB / 2 - 1;
   localparam int STOP_PT  = 9 * CPB + CPB / 2 - 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        io_write = 1'b0;
   logic [63:0] io_data = '0;
   logic        tx, busy, fifo_full, overflow;
   logic [2:0]  fifo_level;

   int n_assert = 0;
   int n_fail = 0;

   io_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .io_write(io_write), .io_data(io_data),
      .tx(tx), .busy(busy), .fifo_full(fifo_full), .overflow(overflow),
      .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   // UART receiver: detects the start bit on a falling clock edge and samples each bit mid-way.
   logic [7:0] rx_q[$];
   logic [7:0] mon_byte = '0;
   bit         mon_busy = 1'b0;
   int         mon_cnt = 0;
   int         frame_err = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         mon_busy <= 1'b0;
         mon_cnt  <= 0;
      end else if (!mon_busy) begin
         if (tx === 1'b0) begin
            mon_busy <= 1'b1;
            mon_cnt  <= 1;
         end
      end else begin
         mon_cnt <= mon_cnt + 1;
         if (mon_cnt == STOP_PT) begin
            if (tx !== 1'b1) frame_err <= frame_err + 1;
            rx_q.push_back(mon_byte);
            mon_busy <= 1'b0;
         end else if (mon_cnt >= FIRST_PT && ((mon_cnt - FIRST_PT) % CPB) == 0) begin
            mon_byte[(mon_cnt - FIRST_PT) / CPB] <= tx;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [63:0] w);
      io_data  = w;
      io_write = 1'b1;
      tick();
      io_write = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget, output int cyc);
      cyc = 0;
      while (busy && cyc < budget) begin
         tick();
         cyc++;
      end
      chk({tag, " idle within budget"}, {63'd0, busy}, 64'd0);
   endtask

   function automatic logic [7:0] exp_byte(input logic [63:0] w, input int j);
      if (j < 8) return w[8*j +: 8];
      return 8'h0A;
   endfunction

   task automatic check_word(input string tag, input logic [63:0] w, input int base);
      logic [7:0] got;
      for (int j = 0; j < BPW; j++) begin
         got = (base + j < rx_q.size()) ? rx_q[base + j] : 8'hxx;
         chk($sformatf("%s byte %0d", tag, j), {56'd0, got}, {56'd0, exp_byte(w, j)});
      end
   endtask

   initial begin
      logic [63:0] words [6];
      int cyc;

      // T1: reset held for three edges
      repeat (3) tick();
      chk("T1 tx", {63'd0, tx}, 64'd1);
      chk("T1 busy", {63'd0, busy}, 64'd0);
      chk("T1 level", {61'd0, fifo_level}, 64'd0);
      chk("T1 overflow", {63'd0, overflow}, 64'd0);
      chk("T1 full", {63'd0, fifo_full}, 64'd0);
      rst_n = 1'b1;
      tick();

      // T2: one word; tx drops the edge after the write, busy lasts one word time plus one cycle
      write_word(64'h0807060504030201);
      chk("T2 level after write", {61'd0, fifo_level}, 64'd1);
      chk("T2 tx still idle", {63'd0, tx}, 64'd1);
      chk("T2 busy", {63'd0, busy}, 64'd1);
      tick();
      chk("T2 tx start bit", {63'd0, tx}, 64'd0);
      chk("T2 level after pop", {61'd0, fifo_level}, 64'd0);
      wait_idle("T2", 2000, cyc);
      chk("T2 busy cycles", 64'(cyc + 1), 64'(WORD_CYC + 1));
      chk("T2 byte count", 64'(rx_q.size()), 64'(BPW));
      check_word("T2", 64'h0807060504030201, 0);
      repeat (3) tick();
      rx_q.delete();

      // T3/T4: fill the FIFO, push on the pop edge, then overflow
      for (int k = 0; k < 6; k++) words[k] = {8{8'hA0 + 8'(k * 16)}} + 64'h0706050403020100;
      for (int k = 0; k < 5; k++) write_word(words[k]);
      chk("T3 level full", {61'd0, fifo_level}, 64'd4);
      chk("T3 fifo_full", {63'd0, fifo_full}, 64'd1);
      chk("T3 overflow clear", {63'd0, overflow}, 64'd0);
      repeat (WORD_CYC - 3) tick();
      chk("T4 level before pop", {61'd0, fifo_level}, 64'd4);
      chk("T4 tx idle before pop", {63'd0, tx}, 64'd1);
      write_word(words[5]);
      chk("T4 level after push+pop", {61'd0, fifo_level}, 64'd4);
      chk("T4 fifo_full", {63'd0, fifo_full}, 64'd1);
      chk("T4 overflow clear", {63'd0, overflow}, 64'd0);
      chk("T4 tx start bit", {63'd0, tx}, 64'd0);
      tick();
      write_word(64'hDEADBEEFDEADBEEF);
      chk("T3 overflow set", {63'd0, overflow}, 64'd1);
      chk("T3 level after drop", {61'd0, fifo_level}, 64'd4);
      wait_idle("T3", 5 * (WORD_CYC + 1) + 50, cyc);
      chk("T3 byte count", 64'(rx_q.size()), 64'(6 * BPW));
      for (int k = 0; k < 6; k++) check_word($sformatf("T3 word %0d", k), words[k], k * BPW);
      chk("T3 overflow sticky", {63'd0, overflow}, 64'd1);
      repeat (3) tick();

      // T5: reset during the data bits of byte 3 with one more word still queued
      write_word(64'h1122334455667788);
      write_word(64'hCAFECAFECAFECAFE);
      repeat (128) tick();
      chk("T5 tx byte3 bit1", {63'd0, tx}, 64'd0);
      chk("T5 level before reset", {61'd0, fifo_level}, 64'd1);
      rst_n = 1'b0;
      tick();
      chk("T5 tx after reset", {63'd0, tx}, 64'd1);
      chk("T5 level after reset", {61'd0, fifo_level}, 64'd0);
      chk("T5 busy after reset", {63'd0, busy}, 64'd0);
      chk("T5 overflow after reset", {63'd0, overflow}, 64'd0);
      rst_n = 1'b1;
      tick();
      rx_q.delete();
      write_word(64'h0123456789ABCDEF);
      wait_idle("T5", 2000, cyc);
      chk("T5 busy cycles", 64'(cyc), 64'(WORD_CYC + 1));
      chk("T5 byte count", 64'(rx_q.size()), 64'(BPW));
      check_word("T5", 64'h0123456789ABCDEF, 0);
      repeat (3) tick();
      rx_q.delete();

      // T6: all-zero word (trailing 0x0A frame when the newline option is built in)
      write_word(64'h0);
      wait_idle("T6", 2000, cyc);
      chk("T6 busy cycles", 64'(cyc), 64'(WORD_CYC + 1));
      chk("T6 byte count", 64'(rx_q.size()), 64'(BPW));
      check_word("T6", 64'h0, 0);
      chk("framing errors", 64'(frame_err), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
